// File: rtl/data_access_unit_if.sv
// data_access_unit_if: bundles the M-stage request, data-memory and vector status signals.
//   master: pipeline/memory side, drives requests and DARData.
//   slave : data_access_unit, drives memory address/data and the vector status.
interface data_access_unit_if #(
  parameter int LANES  = 16,
  parameter int LANE_W = 8,
  parameter int ADDR_W = 32
);
  logic                    MemReqM;
  logic                    VecM;
  logic                    MemWriteM;
  logic [ADDR_W-1:0]       ALUResultM;
  logic [LANE_W-1:0]       WriteDataM;
  logic [LANES*LANE_W-1:0] WriteDataVM;
  logic [LANE_W-1:0]       DARData;
  logic [ADDR_W-1:0]       DAAddr;
  logic                    DAWE;
  logic [LANE_W-1:0]       DAWData;
  logic [LANE_W-1:0]       ReadDataM;
  logic [LANES*LANE_W-1:0] ReadDataVM;
  logic                    BusyDA;
  logic                    DoneDA;
  modport master (
    output MemReqM, VecM, MemWriteM, ALUResultM, WriteDataM, WriteDataVM, DARData,
    input  DAAddr, DAWE, DAWData, ReadDataM, ReadDataVM, BusyDA, DoneDA
  );
  modport slave (
    input  MemReqM, VecM, MemWriteM, ALUResultM, WriteDataM, WriteDataVM, DARData,
    output DAAddr, DAWE, DAWData, ReadDataM, ReadDataVM, BusyDA, DoneDA
  );
endinterface

// File: rtl/data_access_unit.sv
// data_access_unit: M-stage sequencer; scalar accesses pass through, vector accesses are serialized per lane.
//   clk, rst (sync, active-low)
//   bus (slave): M-stage request in, data-memory address/data out, BusyDA/DoneDA status out.
//   BusyCyclesDA: saturating busy-cycle counter, present only with DA_PERF_CNT_EN defined.
module data_access_unit #(
  parameter int LANES  = 16,
  parameter int LANE_W = 8,
  parameter int ADDR_W = 32
) (
  input logic clk,
  input logic rst,
  data_access_unit_if.slave bus
`ifdef DA_PERF_CNT_EN
  ,
  output logic [31:0] BusyCyclesDA
`endif
);
  localparam int LW = $clog2(LANES);
  typedef enum logic [2:0] {IDLE, VWR, VRD, VRD_LAST, DONE} state_t;
  state_t                  state_q, state_d;
  logic [LW-1:0]           lane_q, lane_d;
  logic [ADDR_W-1:0]       base_q, base_d;
  logic [LANES*LANE_W-1:0] wdata_q, wdata_d;
  logic [LANES*LANE_W-1:0] rdv_q, rdv_d;
  logic [ADDR_W-1:0]       addr;
  logic [LANE_W-1:0]       wd;
  logic                    we;
  logic                    busy;
  logic                    done;
  logic                    last;
  assign last = lane_q == LW'(LANES - 1);
  always_comb begin
    state_d = state_q;
    lane_d = lane_q;
    base_d = base_q;
    wdata_d = wdata_q;
    rdv_d = rdv_q;
    addr = bus.ALUResultM;
    wd = bus.WriteDataM;
    we = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      IDLE: begin
        we = bus.MemReqM & ~bus.VecM & bus.MemWriteM;
        if (bus.MemReqM && bus.VecM) begin
          busy = 1'b1;
          base_d = bus.ALUResultM;
          wdata_d = bus.WriteDataVM;
          lane_d = '0;
          state_d = bus.MemWriteM ? VWR : VRD;
        end
      end
      VWR: begin
        busy = 1'b1;
        addr = base_q + ADDR_W'(lane_q);
        wd = wdata_q[lane_q*LANE_W +: LANE_W];
        we = 1'b1;
        lane_d = last ? '0 : lane_q + LW'(1);
        state_d = last ? DONE : VWR;
      end
      VRD: begin
        busy = 1'b1;
        addr = base_q + ADDR_W'(lane_q);
        // read data trails the issued address by one cycle
        if (lane_q != '0) rdv_d[(lane_q - LW'(1))*LANE_W +: LANE_W] = bus.DARData;
        lane_d = last ? '0 : lane_q + LW'(1);
        state_d = last ? VRD_LAST : VRD;
      end
      VRD_LAST: begin
        busy = 1'b1;
        addr = base_q;
        rdv_d[(LANES-1)*LANE_W +: LANE_W] = bus.DARData;
        state_d = DONE;
      end
      default: begin
        done = 1'b1;
        state_d = IDLE;
      end
    endcase
    if (!rst) begin
      addr = '0;
      wd = '0;
      we = 1'b0;
      busy = 1'b0;
      done = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      lane_q <= '0;
      base_q <= '0;
      wdata_q <= '0;
      rdv_q <= '0;
    end else begin
      state_q <= state_d;
      lane_q <= lane_d;
      base_q <= base_d;
      wdata_q <= wdata_d;
      rdv_q <= rdv_d;
    end
  end
  assign bus.DAAddr = addr;
  assign bus.DAWData = wd;
  assign bus.DAWE = we;
  assign bus.BusyDA = busy;
  assign bus.DoneDA = done;
  assign bus.ReadDataM = bus.DARData;
  assign bus.ReadDataVM = rdv_q;
`ifdef DA_PERF_CNT_EN
  logic [31:0] busy_cnt_q, busy_cnt_d;
  always_comb busy_cnt_d = (busy && busy_cnt_q != '1) ? busy_cnt_q + 32'd1 : busy_cnt_q;
  always_ff @(posedge clk) busy_cnt_q <= !rst ? '0 : busy_cnt_d;
  assign BusyCyclesDA = busy_cnt_q;
`endif
endmodule

// File: tb/tb_data_access_unit.sv
// tb_data_access_unit: directed checks of scalar pass-through, vector store/load, wrap-around and reset.
module tb_data_access_unit;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;
  data_access_unit_if #(.LANES(16), .LANE_W(8), .ADDR_W(32)) bus ();
`ifdef DA_PERF_CNT_EN
  logic [31:0] busy_cycles;
`endif
  data_access_unit #(.LANES(16), .LANE_W(8), .ADDR_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef DA_PERF_CNT_EN
    ,
    .BusyCyclesDA(busy_cycles)
`endif
  );
  always #5 clk = ~clk;
  // memory whose byte at address a is a[7:0]; read data is registered
  always @(posedge clk) bus.DARData <= bus.DAAddr[7:0];
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b0;
    bus.MemReqM = 1'b1;
    bus.VecM = 1'b1;
    bus.MemWriteM = 1'b1;
    bus.ALUResultM = 32'h123;
    bus.WriteDataM = 8'h5A;
    bus.WriteDataVM = 128'h0F0E0D0C0B0A09080706050403020100;
    step();
    check("rst_busy", 128'(bus.BusyDA), 0);
    check("rst_we", 128'(bus.DAWE), 0);
    check("rst_addr", 128'(bus.DAAddr), 0);
    check("rst_wdata", 128'(bus.DAWData), 0);
    check("rst_done", 128'(bus.DoneDA), 0);
    check("rst_rdv", bus.ReadDataVM, 0);
    rst = 1'b1;
    bus.MemReqM = 1'b0;
    step();
    check("post_rst_busy", 128'(bus.BusyDA), 0);
    check("post_rst_done", 128'(bus.DoneDA), 0);
    step();
    check("post_rst_busy2", 128'(bus.BusyDA), 0);
    bus.MemReqM = 1'b1;
    bus.VecM = 1'b0;
    bus.MemWriteM = 1'b1;
    bus.ALUResultM = 32'h40;
    bus.WriteDataM = 8'hAB;
    #1;
    check("sst_we", 128'(bus.DAWE), 1);
    check("sst_addr", 128'(bus.DAAddr), 128'h40);
    check("sst_wdata", 128'(bus.DAWData), 128'hAB);
    check("sst_busy", 128'(bus.BusyDA), 0);
    bus.MemWriteM = 1'b0;
    bus.ALUResultM = 32'h203;
    #1;
    check("sld_we", 128'(bus.DAWE), 0);
    step();
    check("sld_data", 128'(bus.ReadDataM), 128'h03);
    check("sld_busy", 128'(bus.BusyDA), 0);
    bus.VecM = 1'b1;
    bus.MemWriteM = 1'b1;
    bus.ALUResultM = 32'h100;
    for (int c = 0; c <= 17; c++) begin
      if (c > 0) step(); else #1;
      check($sformatf("vst_busy%0d", c), 128'(bus.BusyDA), 128'(c <= 16));
      check($sformatf("vst_we%0d", c), 128'(bus.DAWE), 128'(c >= 1 && c <= 16));
      check($sformatf("vst_done%0d", c), 128'(bus.DoneDA), 128'(c == 17));
      if (c >= 1 && c <= 16) begin
        check($sformatf("vst_addr%0d", c), 128'(bus.DAAddr), 128'(32'h100 + c - 1));
        check($sformatf("vst_wdata%0d", c), 128'(bus.DAWData), 128'(c - 1));
      end
`ifdef DA_PERF_CNT_EN
      if (c == 17) check("vst_perf", 128'(busy_cycles), 128'd17);
`endif
    end
    step();
    bus.MemWriteM = 1'b0;
    bus.ALUResultM = 32'h200;
    for (int c = 0; c <= 18; c++) begin
      if (c > 0) step(); else #1;
      check($sformatf("vld_busy%0d", c), 128'(bus.BusyDA), 128'(c <= 17));
      check($sformatf("vld_we%0d", c), 128'(bus.DAWE), 0);
      check($sformatf("vld_done%0d", c), 128'(bus.DoneDA), 128'(c == 18));
      if (c >= 1 && c <= 16) check($sformatf("vld_addr%0d", c), 128'(bus.DAAddr), 128'(32'h200 + c - 1));
    end
    check("vld_data", bus.ReadDataVM, 128'h0F0E0D0C0B0A09080706050403020100);
    bus.MemReqM = 1'b0;
    step();
    check("vld_hold", bus.ReadDataVM, 128'h0F0E0D0C0B0A09080706050403020100);
    check("vld_idle_busy", 128'(bus.BusyDA), 0);
    bus.MemReqM = 1'b1;
    bus.MemWriteM = 1'b1;
    bus.ALUResultM = 32'hFFFFFFF8;
    for (int c = 0; c <= 17; c++) begin
      if (c > 0) step(); else #1;
      check($sformatf("wrap_we%0d", c), 128'(bus.DAWE), 128'(c >= 1 && c <= 16));
      if (c >= 1 && c <= 8) check($sformatf("wrap_addr%0d", c), 128'(bus.DAAddr), 128'(32'hFFFFFFF7 + c));
      if (c >= 9 && c <= 16) check($sformatf("wrap_addr%0d", c), 128'(bus.DAAddr), 128'(c - 9));
      if (c == 17) check("wrap_done", 128'(bus.DoneDA), 1);
    end
    bus.MemReqM = 1'b0;
    step();
    bus.MemReqM = 1'b1;
    bus.MemWriteM = 1'b0;
    bus.ALUResultM = 32'h200;
    for (int c = 1; c <= 5; c++) step();
    check("mid_busy_pre", 128'(bus.BusyDA), 1);
    rst = 1'b0;
    #1;
    check("mid_busy_rst", 128'(bus.BusyDA), 0);
    check("mid_addr_rst", 128'(bus.DAAddr), 0);
    step();
    check("mid_busy", 128'(bus.BusyDA), 0);
    check("mid_we", 128'(bus.DAWE), 0);
    check("mid_rdv", bus.ReadDataVM, 0);
    rst = 1'b1;
    bus.MemReqM = 1'b0;
    step();
    check("mid_idle_busy", 128'(bus.BusyDA), 0);
    check("mid_idle_done", 128'(bus.DoneDA), 0);
    bus.MemReqM = 1'b1;
    bus.VecM = 1'b0;
    bus.ALUResultM = 32'h205;
    step();
    check("mid_sld_data", 128'(bus.ReadDataM), 128'h05);
    check("mid_sld_busy", 128'(bus.BusyDA), 0);
    check("mid_sld_we", 128'(bus.DAWE), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
